// File: rtl/mult_seq_param.sv
// mult_seq_param
//   Sequential shift-add multiplier. It produces one 2*WIDTH-bit product
//   for each accepted start request.
//   Operands are captured as magnitudes, together with a sign flag. Over
//   WIDTH iterations the magnitudes are shift-added into an accumulator.
//   The sign is applied once, when the result is registered.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   init         start request, accepted in IDLE or DONE
//   a, b         multiplicand / multiplier, captured when init is accepted
//   signed_mode  1 = two's-complement operands/result, captured with a/b
//   result       registered product, held until the next completion
//   done         one-cycle pulse: result is new this cycle
//   busy         high while a multiplication is in progress
module mult_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic [2*WIDTH-1:0] result,
  output logic               done,
  output logic               busy
);

  localparam int P_W   = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sign_q, sign_d;
  logic [P_W-1:0]   acc_q, acc_d;
  logic [P_W-1:0]   res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [P_W-1:0]   acc_sum;

  // The WIDTH-bit unsigned result of -(-2^(WIDTH-1)) is 2^(WIDTH-1).
  // That is the correct magnitude, so no extra bit is needed.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic sm);
    return (sm && v[WIDTH-1]) ? WIDTH'(-v) : v;
  endfunction

  // Negating a zero magnitude gives zero, so no negative-zero artefact appears.
  function automatic logic [P_W-1:0] apply_sign(input logic [P_W-1:0] mag,
                                                input logic neg);
    return neg ? P_W'(-mag) : mag;
  endfunction

  assign acc_sum = acc_q + (b_q[0] ? (P_W'(a_q) << cnt_q) : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      acc_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    acc_d   = acc_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    case (state_q)
      // DONE accepts a start just as IDLE does, so back-to-back products are possible.
      IDLE, DONE: begin
        if (init) begin
          state_d = CALC;
          a_d     = magnitude(a, signed_mode);
          b_d     = magnitude(b, signed_mode);
          sign_d  = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d = acc_sum;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          res_d   = apply_sign(acc_sum, sign_q);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign result = res_q;
  assign done   = (state_q == DONE);
  assign busy   = (state_q == CALC);

endmodule
